led_scan_capture: RTL and testbench

//  Receiving end of the 8x8 LED row-scan bus and the 2-digit 7-segment bus driven by the game core.

---
 rtl/scan_pkg.sv | 46 ++++
 rtl/seg7_decode.sv | 27 ++
 rtl/led_scan_capture.sv | 254 +++++++++++++++++++++++++
 tb/tb_led_scan_capture.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the LED scan / 7-segment capture block.
// Bus widths, FSM encoding, COM digit codes and segment patterns.
package scan_pkg;

    localparam int unsigned ROWS    = 8;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned COL_W   = 8;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned COM_W   = 2;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SCORE_W = 7;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SWEEP  = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

    localparam logic [COM_W-1:0] COM_ONES = 2'b10;
    localparam logic [COM_W-1:0] COM_TENS = 2'b01;

    // {a,b,c,d,e,f,g}, active-low
    localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;

    typedef struct packed {
        logic [COL_W-1:0] red;
        logic [COL_W-1:0] grn;
        logic [COL_W-1:0] blu;
    } rgb_row_t;

    typedef struct packed {
        logic               valid;
        logic [DIGIT_W-1:0] digit;
    } seg_digit_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low 7-segment pattern to BCD digit decoder.
// Unknown patterns return digit 4'hF with valid cleared.
module seg7_decode
    import scan_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output seg_digit_t       dec_c
);

    always_comb begin
        dec_c = '{valid: 1'b1, digit: 4'd0};
        case (seg)
            SEG_0:   dec_c.digit = 4'd0;
            SEG_1:   dec_c.digit = 4'd1;
            SEG_2:   dec_c.digit = 4'd2;
            SEG_3:   dec_c.digit = 4'd3;
            SEG_4:   dec_c.digit = 4'd4;
            SEG_5:   dec_c.digit = 4'd5;
            SEG_6:   dec_c.digit = 4'd6;
            SEG_7:   dec_c.digit = 4'd7;
            SEG_8:   dec_c.digit = 4'd8;
            SEG_9:   dec_c.digit = 4'd9;
            default: dec_c = '{valid: 1'b0, digit: 4'hF};
        endcase
    end

endmodule

// File: rtl/led_scan_capture.sv
// Rebuilds a double-buffered 8x8 RGB frame from the row-scan bus and
// recovers the two-digit score from the multiplexed 7-segment bus.
module led_scan_capture
    import scan_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [ROW_W-1:0]   scan_row,
    input  logic [COL_W-1:0]   scan_red,
    input  logic [COL_W-1:0]   scan_grn,
    input  logic [COL_W-1:0]   scan_blu,
    input  logic               scan_en,
    input  logic [SEG_W-1:0]   seg,
    input  logic [COM_W-1:0]   com,
    input  logic [ROW_W-1:0]   rd_row,
    output logic [COL_W-1:0]   rd_red,
    output logic [COL_W-1:0]   rd_grn,
    output logic [COL_W-1:0]   rd_blu,
    output logic               frame_valid,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               sync_err,
    output logic               stalled,
    output logic [SCORE_W-1:0] score,
    output logic               seg_err
);

    localparam int unsigned SET_W  = $clog2(SETTLE + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned SYNC_W = ROW_W + 3 * COL_W + 1 + SEG_W + COM_W;

    logic [SYNC_W-1:0] sync1, sync2;
    logic [ROW_W-1:0]  row_s;
    logic [COL_W-1:0]  red_s, grn_s, blu_s;
    logic              en_s;
    logic [SEG_W-1:0]  seg_s;
    logic [COM_W-1:0]  com_s;

    // Two-flop synchroniser for every asynchronous input bit
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {scan_row, scan_red, scan_grn, scan_blu, scan_en, seg, com};
            sync2 <= sync1;
        end
    end

    assign {row_s, red_s, grn_s, blu_s, en_s, seg_s, com_s} = sync2;

    // Row settle: one sample per row visit once stable long enough
    logic [ROW_W-1:0] row_q;
    logic [SET_W-1:0] row_cnt;
    logic             row_done;
    logic             row_chg_c, row_smp_c, smp_c;

    assign row_chg_c = (row_s != row_q);
    assign row_smp_c = !row_chg_c && !row_done && (row_cnt == SET_W'(SETTLE - 1));
    assign smp_c     = row_smp_c && en_s;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            row_q    <= '0;
            row_cnt  <= '0;
            row_done <= 1'b0;
        end else begin
            row_q <= row_s;
            if (row_chg_c) begin
                row_cnt  <= '0;
                row_done <= 1'b0;
            end else if (row_smp_c) begin
                row_done <= 1'b1;
            end else if (!row_done) begin
                row_cnt <= row_cnt + SET_W'(1);
            end
        end
    end

    scan_state_t      state, state_n;
    logic [ROW_W-1:0] exp_row, exp_n;
    logic             shd_we_c, sync_err_c, commit_c;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= HUNT;
            exp_row <= '0;
        end else begin
            state   <= state_n;
            exp_row <= exp_n;
        end
    end

    // Sweep tracking: rows must arrive 0..7 with the matrix enabled
    always_comb begin
        state_n    = state;
        exp_n      = exp_row;
        shd_we_c   = 1'b0;
        sync_err_c = 1'b0;
        commit_c   = 1'b0;
        unique case (state)
            HUNT: begin
                if (smp_c && (row_s == '0)) begin
                    shd_we_c = 1'b1;
                    exp_n    = ROW_W'(1);
                    state_n  = SWEEP;
                end
            end
            SWEEP: begin
                if (!en_s) begin
                    state_n = HUNT;
                end else if (smp_c) begin
                    if (row_s == exp_row) begin
                        shd_we_c = 1'b1;
                        exp_n    = exp_row + ROW_W'(1);
                        if (row_s == ROW_W'(ROWS - 1)) begin
                            state_n = COMMIT;
                        end
                    end else begin
                        sync_err_c = 1'b1;
                        if (row_s == '0) begin
                            shd_we_c = 1'b1;
                            exp_n    = ROW_W'(1);
                        end else begin
                            state_n = HUNT;
                        end
                    end
                end
            end
            COMMIT: begin
                commit_c = 1'b1;
                state_n  = HUNT;
            end
            default: state_n = HUNT;
        endcase
    end

    rgb_row_t shadow  [ROWS];
    rgb_row_t visible [ROWS];
    rgb_row_t wr_data;

    assign wr_data = '{red: ~red_s, grn: ~grn_s, blu: ~blu_s};

    // Frame buffers and read port; a read on the commit edge sees the old frame
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) begin
                shadow[i]  <= '0;
                visible[i] <= '0;
            end
            rd_red      <= '0;
            rd_grn      <= '0;
            rd_blu      <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            sync_err    <= 1'b0;
        end else begin
            if (shd_we_c) begin
                shadow[row_s] <= wr_data;
            end
            if (commit_c) begin
                for (int i = 0; i < ROWS; i++) begin
                    visible[i] <= shadow[i];
                end
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            frame_valid <= commit_c;
            sync_err    <= sync_err_c;
            rd_red      <= visible[rd_row].red;
            rd_grn      <= visible[rd_row].grn;
            rd_blu      <= visible[rd_row].blu;
        end
    end

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            stalled <= 1'b0;
        end else if (row_chg_c) begin
            tmo_cnt <= '0;
            stalled <= 1'b0;
        end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
            stalled <= 1'b1;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Digit capture: one decode per COM visit after it settles
    logic [COM_W-1:0]   com_q;
    logic [SET_W-1:0]   com_cnt;
    logic               com_done;
    logic               com_chg_c, com_smp_c, ones_smp_c, tens_smp_c;
    seg_digit_t         dec_c;
    logic [DIGIT_W-1:0] ones_dig, tens_dig;
    logic               ones_vld, tens_vld;

    assign com_chg_c  = (com_s != com_q);
    assign com_smp_c  = !com_chg_c && !com_done && (com_cnt == SET_W'(SETTLE - 1));
    assign ones_smp_c = com_smp_c && (com_s == COM_ONES);
    assign tens_smp_c = com_smp_c && (com_s == COM_TENS);

    seg7_decode u_seg7_decode (
        .seg   (seg_s),
        .dec_c (dec_c)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            com_q    <= '0;
            com_cnt  <= '0;
            com_done <= 1'b0;
        end else begin
            com_q <= com_s;
            if (com_chg_c) begin
                com_cnt  <= '0;
                com_done <= 1'b0;
            end else if (com_smp_c) begin
                com_done <= 1'b1;
            end else if (!com_done) begin
                com_cnt <= com_cnt + SET_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ones_dig <= '0;
            tens_dig <= '0;
            ones_vld <= 1'b0;
            tens_vld <= 1'b0;
            seg_err  <= 1'b0;
            score    <= '0;
        end else begin
            if (ones_smp_c) begin
                ones_dig <= dec_c.digit;
                ones_vld <= dec_c.valid;
            end
            if (tens_smp_c) begin
                tens_dig <= dec_c.digit;
                tens_vld <= dec_c.valid;
            end
            seg_err <= (ones_smp_c || tens_smp_c) && !dec_c.valid;
            if (ones_vld && tens_vld) begin
                score <= SCORE_W'(tens_dig) * SCORE_W'(10) + SCORE_W'(ones_dig);
            end
        end
    end

endmodule

// File: tb/tb_led_scan_capture.sv
// Directed bench for led_scan_capture: frame rebuild, sync errors, stall,
// score decode, reset mid-sweep and frame counter wrap.
module tb_led_scan_capture;

    localparam int unsigned TMO = 200;

    logic       CLK = 1'b0;
    logic       reset;
    logic [2:0] scan_row;
    logic [7:0] scan_red, scan_grn, scan_blu;
    logic       scan_en;
    logic [6:0] seg;
    logic [1:0] com;
    logic [2:0] rd_row;
    logic [7:0] rd_red, rd_grn, rd_blu;
    logic       frame_valid;
    logic [7:0] frame_cnt;
    logic       sync_err;
    logic       stalled;
    logic [6:0] score;
    logic       seg_err;

    always #5 CLK = ~CLK;

    led_scan_capture #(.SETTLE(4), .TIMEOUT(TMO)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .scan_row    (scan_row),
        .scan_red    (scan_red),
        .scan_grn    (scan_grn),
        .scan_blu    (scan_blu),
        .scan_en     (scan_en),
        .seg         (seg),
        .com         (com),
        .rd_row      (rd_row),
        .rd_red      (rd_red),
        .rd_grn      (rd_grn),
        .rd_blu      (rd_blu),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt),
        .sync_err    (sync_err),
        .stalled     (stalled),
        .score       (score),
        .seg_err     (seg_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int fv_seen  = 0;
    int se_seen  = 0;
    int sg_seen  = 0;

    always @(posedge CLK) begin
        if (frame_valid) fv_seen++;
        if (sync_err)    se_seen++;
        if (seg_err)     sg_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] red_pix(input int r);
        return 8'(1 << r);
    endfunction

    function automatic logic [7:0] grn_pix(input int r, input int k);
        return 8'(k * 8 + r);
    endfunction

    function automatic logic [7:0] blu_pix(input int r, input int k);
        return 8'(255 - r - k);
    endfunction

    // All stimulus tasks start and end on a falling edge
    task automatic drive_row(input int r, input int k, input logic en, input int hold);
        scan_row = 3'(r);
        scan_red = ~red_pix(r);
        scan_grn = ~grn_pix(r, k);
        scan_blu = ~blu_pix(r, k);
        scan_en  = en;
        repeat (hold) @(negedge CLK);
    endtask

    task automatic sweep(input int k, input int hold);
        for (int r = 0; r < 8; r++) drive_row(r, k, 1'b1, hold);
        repeat (4) @(negedge CLK);
    endtask

    task automatic check_row(input string tag, input int r, input logic [7:0] er,
                             input logic [7:0] eg, input logic [7:0] eb);
        rd_row = 3'(r);
        @(negedge CLK);
        check_eq($sformatf("%s_r%0d_red", tag, r), 32'(rd_red), 32'(er));
        check_eq($sformatf("%s_r%0d_grn", tag, r), 32'(rd_grn), 32'(eg));
        check_eq($sformatf("%s_r%0d_blu", tag, r), 32'(rd_blu), 32'(eb));
    endtask

    task automatic set_seg(input logic [1:0] c, input logic [6:0] s);
        com = c;
        seg = s;
        repeat (10) @(negedge CLK);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0, se0, sg0;
        logic got;

        reset    = 1'b0;
        scan_row = 3'd7;
        scan_red = 8'hFF;
        scan_grn = 8'hFF;
        scan_blu = 8'hFF;
        scan_en  = 1'b0;
        seg      = 7'h7F;
        com      = 2'b00;
        rd_row   = 3'd0;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset state
        check_eq("rst_frame_valid", 32'(frame_valid), 32'd0);
        check_eq("rst_frame_cnt",   32'(frame_cnt),   32'd0);
        check_eq("rst_sync_err",    32'(sync_err),    32'd0);
        check_eq("rst_stalled",     32'(stalled),     32'd0);
        check_eq("rst_score",       32'(score),       32'd0);
        check_eq("rst_seg_err",     32'(seg_err),     32'd0);
        check_row("rst", 0, 8'h00, 8'h00, 8'h00);

        // 1: full in-order sweep
        fv0 = fv_seen;
        sweep(1, 20);
        check_eq("t1_frame_pulses", 32'(fv_seen - fv0), 32'd1);
        check_eq("t1_frame_cnt",    32'(frame_cnt),     32'd1);
        check_row("t1", 3, 8'h08, grn_pix(3, 1), blu_pix(3, 1));
        check_row("t1", 0, 8'h01, grn_pix(0, 1), blu_pix(0, 1));

        // 2: out-of-order row 5
        fv0 = fv_seen; se0 = se_seen;
        drive_row(0, 5, 1'b1, 8);
        drive_row(1, 5, 1'b1, 8);
        drive_row(2, 5, 1'b1, 8);
        drive_row(5, 5, 1'b1, 8);
        repeat (4) @(negedge CLK);
        check_eq("t2_sync_err",     32'(se_seen - se0), 32'd1);
        check_eq("t2_no_frame",     32'(fv_seen - fv0), 32'd0);
        check_row("t2_keep", 3, 8'h08, grn_pix(3, 1), blu_pix(3, 1));

        // 3a: row 3 held only 3 cycles is never stored, so row 4 is out of order
        fv0 = fv_seen; se0 = se_seen;
        for (int r = 0; r < 3; r++) drive_row(r, 6, 1'b1, 8);
        drive_row(3, 6, 1'b1, 3);
        for (int r = 4; r < 8; r++) drive_row(r, 6, 1'b1, 8);
        repeat (4) @(negedge CLK);
        check_eq("t3_short_err",    32'(se_seen - se0), 32'd1);
        check_eq("t3_short_noframe", 32'(fv_seen - fv0), 32'd0);

        // 3b: matrix disabled mid-sweep aborts without error
        fv0 = fv_seen; se0 = se_seen;
        for (int r = 0; r < 3; r++) drive_row(r, 7, 1'b1, 8);
        drive_row(3, 7, 1'b0, 8);
        for (int r = 4; r < 8; r++) drive_row(r, 7, 1'b1, 8);
        repeat (4) @(negedge CLK);
        check_eq("t3_en_noerr",     32'(se_seen - se0), 32'd0);
        check_eq("t3_en_noframe",   32'(fv_seen - fv0), 32'd0);
        check_row("t3_keep", 3, 8'h08, grn_pix(3, 1), blu_pix(3, 1));

        // 3c: stall detection
        drive_row(2, 0, 1'b0, 100);
        check_eq("t3_stall_early",  32'(stalled), 32'd0);
        repeat (150) @(negedge CLK);
        check_eq("t3_stall_set",    32'(stalled), 32'd1);
        drive_row(3, 0, 1'b0, 5);
        check_eq("t3_stall_clear",  32'(stalled), 32'd0);

        // 4: score decode
        sg0 = sg_seen;
        set_seg(2'b10, 7'b0100100);
        set_seg(2'b01, 7'b1001111);
        check_eq("t4_score_15",     32'(score), 32'd15);
        check_eq("t4_no_seg_err",   32'(sg_seen - sg0), 32'd0);
        set_seg(2'b10, 7'b1111111);
        check_eq("t4_seg_err",      32'(sg_seen - sg0), 32'd1);
        check_eq("t4_score_held",   32'(score), 32'd15);
        set_seg(2'b11, 7'b0000000);
        check_eq("t4_com11_ignored", 32'(score), 32'd15);
        set_seg(2'b10, 7'b0000110);
        check_eq("t4_score_13",     32'(score), 32'd13);
        set_seg(2'b01, 7'b0000000);
        check_eq("t4_score_83",     32'(score), 32'd83);
        check_eq("t4_seg_err_total", 32'(sg_seen - sg0), 32'd1);

        // 5: reset in the middle of a sweep
        for (int r = 0; r < 4; r++) drive_row(r, 9, 1'b1, 8);
        drive_row(4, 9, 1'b1, 3);
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        check_eq("t5_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("t5_rst_score",     32'(score),     32'd0);
        check_row("t5_rst", 1, 8'h00, 8'h00, 8'h00);
        fv0 = fv_seen;
        sweep(2, 8);
        check_eq("t5_frame_pulses", 32'(fv_seen - fv0), 32'd1);
        check_eq("t5_frame_cnt",    32'(frame_cnt),     32'd1);
        for (int r = 0; r < 8; r++) check_row("t5", r, red_pix(r), grn_pix(r, 2), blu_pix(r, 2));

        // 6: frame counter wrap and read on the commit edge
        fv0 = fv_seen;
        for (int k = 10; k < 264; k++) sweep(k, 8);
        check_eq("t6_frame_pulses", 32'(fv_seen - fv0), 32'd254);
        check_eq("t6_frame_cnt_255", 32'(frame_cnt), 32'd255);
        rd_row = 3'd2;
        for (int r = 0; r < 7; r++) drive_row(r, 264, 1'b1, 8);
        drive_row(7, 264, 1'b1, 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (frame_valid) got = 1'b1;
        end
        check_eq("t6_commit_seen",  32'(got), 32'd1);
        check_eq("t6_frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        check_eq("t6_same_cycle_old", 32'(rd_grn), 32'(grn_pix(2, 263)));
        @(negedge CLK);
        check_eq("t6_next_cycle_new", 32'(rd_grn), 32'(grn_pix(2, 264)));
        check_eq("t6_next_red",       32'(rd_red), 32'h04);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
